// File: rtl/pattern_count_engine.sv
// Counts occurrences of a 5-bit pattern in a 32-byte buffer: in-byte hits, bytes with a hit,
// and hits across the whole bit stream, then writes the three counts back after the buffer.
module pattern_count_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] dm_addr,
  input  logic [7:0] dm_rd_data,
  output logic       dm_wr_en,
  output logic [7:0] dm_wr_data
);

  // state    | meaning
  // IDLE     | waiting for start, memory port released
  // LOAD_PAT | reading the pattern byte at address 32
  // SCAN     | one data byte per cycle, addresses 0..31
  // WR_CTB   | writing in-byte match count to address 33
  // WR_CTO   | writing count of bytes with a match to address 34
  // WR_CTS   | writing stream-wide match count to address 35
  // DONE     | results valid, memory port released
  typedef enum logic [2:0] {
    IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] pat;
  logic [4:0] index;
  logic [7:0] prev;
  logic [7:0] ctb, cto, cts;
  logic [2:0] m, c;

  function automatic logic [2:0] count_win(input logic [7:0] b, input logic [4:0] p);
    return 3'(b[4:0] == p) + 3'(b[5:1] == p) + 3'(b[6:2] == p) + 3'(b[7:3] == p);
  endfunction

  // Boundary windows combine the previous byte's low nibble with the current high nibble.
  assign m = count_win(dm_rd_data, pat);
  assign c = (index != 5'd0) ? count_win({prev[3:0], dm_rd_data[7:4]}, pat) : 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat   <= '0;
      index <= '0;
      prev  <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
            index <= '0;
          end
        end
        LOAD_PAT: begin
          pat   <= dm_rd_data[4:0];
          index <= '0;
        end
        SCAN: begin
          ctb   <= ctb + 8'(m);
          cto   <= cto + 8'(m != 3'd0);
          cts   <= cts + 8'(m) + 8'(c);
          prev  <= dm_rd_data;
          index <= index + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    dm_addr    = 8'd0;
    dm_wr_en   = 1'b0;
    dm_wr_data = 8'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD_PAT;
      end
      LOAD_PAT: begin
        dm_addr   = 8'd32;
        state_nxt = SCAN;
      end
      SCAN: begin
        dm_addr = {3'b000, index};
        if (index == 5'd31) state_nxt = WR_CTB;
      end
      WR_CTB: begin
        dm_addr    = 8'd33;
        dm_wr_en   = 1'b1;
        dm_wr_data = ctb;
        state_nxt  = WR_CTO;
      end
      WR_CTO: begin
        dm_addr    = 8'd34;
        dm_wr_en   = 1'b1;
        dm_wr_data = cto;
        state_nxt  = WR_CTS;
      end
      WR_CTS: begin
        dm_addr    = 8'd35;
        dm_wr_en   = 1'b1;
        dm_wr_data = cts;
        state_nxt  = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = LOAD_PAT;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: memory model, bit-stream reference model and a write
// scoreboard checking address, data and commit edge of every result write.
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       done, busy, dm_wr_en;
  logic [7:0] dm_addr, dm_rd_data, dm_wr_data;

  logic [7:0] mem [0:255];
  int         cyc = 0;
  int         e0 = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         bad_acc = 0;

  typedef struct {int addr; int data; int edg;} exp_t;
  exp_t sb[$];

  pattern_count_engine dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .dm_addr(dm_addr), .dm_rd_data(dm_rd_data), .dm_wr_en(dm_wr_en), .dm_wr_data(dm_wr_data)
  );

  always #5 clk = ~clk;
  assign dm_rd_data = mem[dm_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_wr_en) mem[dm_addr] <= dm_wr_data;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Writes are committed at the next rising edge, hence cyc+1.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && dm_addr > 8'd35) bad_acc++;
      if (dm_wr_en && dm_addr < 8'd33) bad_acc++;
      if (dm_wr_en) begin
        if (sb.size() == 0) chk("unexp_wr", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", int'(dm_addr), e.addr);
          chk("wr_data", int'(dm_wr_data), e.data);
          chk("wr_edge", cyc + 1 - e0, e.edg);
        end
      end
    end
  end

  // Reference: the 32 bytes as one MSB-first bit stream; every window counts toward cts,
  // windows lying within one byte also count toward ctb/cto.
  task automatic model(output int ctb, output int cto, output int cts);
    bit         stream [256];
    bit         hit [32];
    logic [4:0] p;
    ctb = 0; cto = 0; cts = 0;
    p = mem[32][4:0];
    for (int i = 0; i < 32; i++) begin
      hit[i] = 1'b0;
      for (int j = 0; j < 8; j++) stream[i*8+j] = mem[i][7-j];
    end
    for (int s = 0; s < 252; s++) begin
      bit match;
      match = 1'b1;
      for (int k = 0; k < 5; k++) if (stream[s+k] != p[4-k]) match = 1'b0;
      if (match) begin
        cts++;
        if (s % 8 <= 3) begin
          ctb++;
          hit[s/8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit[i]) cto++;
  endtask

  task automatic fill(input logic [7:0] data_v, input logic [7:0] pat_v);
    for (int i = 0; i < 32; i++) mem[i] = data_v;
    mem[32] = pat_v;
    for (int i = 33; i < 36; i++) mem[i] = 8'hEE;
  endtask

  task automatic run_job(input bit extra_start);
    int ectb, ecto, ects, guard;
    model(ectb, ecto, ects);
    sb.push_back('{33, ectb, 34});
    sb.push_back('{34, ecto, 35});
    sb.push_back('{35, ects, 36});
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 e0 = cyc;
    @(negedge clk); start = 1'b0;
    chk("done_drop", int'(done), 0);
    chk("busy_run", int'(busy), 1);
    if (extra_start) begin
      while (cyc - e0 < 4) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_ignore", int'(busy), 1);
    end
    guard = 0;
    while (!done && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end else begin
      chk("latency", cyc - e0, 36);
      chk("busy_done", int'(busy), 0);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  task automatic chk_res(input string tag, input int a, input int b, input int c);
    chk({tag, "_ctb"}, int'(mem[33]), a);
    chk({tag, "_cto"}, int'(mem[34]), b);
    chk({tag, "_cts"}, int'(mem[35]), c);
  endtask

  initial begin
    int ra, rb, rc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(dm_addr), 0);
    chk("rst_wren", int'(dm_wr_en), 0);
    chk("rst_wdata", int'(dm_wr_data), 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", int'(done), 0);

    fill(8'h00, 8'h15);
    run_job(1'b0);
    chk_res("zeros", 0, 0, 0);

    fill(8'h55, 8'h15);
    run_job(1'b1);
    chk_res("x55", 64, 32, 126);

    run_job(1'b0);
    chk_res("x55_rerun", 64, 32, 126);

    fill(8'hFF, 8'hFF);
    run_job(1'b0);
    chk_res("xff", 128, 32, 252);

    fill(8'h00, 8'h1F);
    mem[5] = 8'h07;
    mem[6] = 8'hC0;
    run_job(1'b0);
    chk_res("cross", 0, 0, 1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[32] = 8'($urandom_range(0, 255));
      for (int i = 33; i < 36; i++) mem[i] = 8'hEE;
      model(ra, rb, rc);
      run_job(1'b0);
      chk_res("rand", ra, rb, rc);
    end

    fill(8'h55, 8'h15);
    for (int i = 33; i < 36; i++) mem[i] = 8'hAA;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 e0 = cyc;
    @(negedge clk); start = 1'b0;
    while (cyc - e0 < 9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wren", int'(dm_wr_en), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_done_late", int'(done), 0);
    chk_res("abort_keep", 8'hAA, 8'hAA, 8'hAA);
    run_job(1'b0);
    chk_res("after_abort", 64, 32, 126);

    chk("addr_range", bad_acc, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_count_engine.md
PATTERN_COUNT_ENGINE -- requirements
Module: pattern_count_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: job request, sampled only in IDLE or DONE.
REQ-004 SHALL have port done, output, 1 bit: job complete; results are in memory.
REQ-005 SHALL have port busy, output, 1 bit: engine owns the data-memory port; top level muxes memory to the engine while high.
REQ-006 SHALL have port dm_addr, output, 8 bits: data-memory address.
REQ-007 SHALL have port dm_rd_data, input, 8 bits: combinational read data for the current dm_addr.
REQ-008 SHALL have port dm_wr_en, output, 1 bit: memory write strobe, committed at the rising edge.
REQ-009 SHALL have port dm_wr_data, output, 8 bits: memory write data.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
REQ-011 IDLE/DONE: start=1 at an edge -> LOAD_PAT, with ctb/cto/cts/index cleared and done dropped at that same edge.
REQ-012 LOAD_PAT: dm_addr=32; latch pat=dm_rd_data[4:0] (bits 7:5 ignored); then go to SCAN with index 0.
REQ-013 SCAN: one byte per cycle, dm_addr=index 0..31; cur=dm_rd_data; prev=byte latched in the previous SCAN cycle.
REQ-014 Per SCAN byte: m = number of matches of pat against cur[4:0], cur[5:1], cur[6:2], cur[7:3] (0..4); ctb += m; cto += 1 if m>0.
REQ-015 Per SCAN byte with index>=1: x={prev[3:0],cur[7:4]}; c = number of matches against x[7:3], x[6:2], x[5:1], x[4:0]; cts += m + c; for index 0, cts += m only.
REQ-016 After index 31 -> WR_CTB (addr 33, data ctb) -> WR_CTO (addr 34, data cto) -> WR_CTS (addr 35, data cts) -> DONE; dm_wr_en=1 only in these three states.
REQ-017 Counters SHALL be 8 bits; maxima are ctb 128, cto 32, cts 252, so no saturation logic is needed.
REQ-018 Latency: start edge E0; memory writes commit at E34/E35/E36; done=1 from E36 onward (36 cycles).
REQ-019 done SHALL stay high in DONE until reset, or until start at an edge relaunches the job.
REQ-020 busy=1 in every state except IDLE and DONE.
REQ-021 start while busy SHALL be ignored, with no restart and no effect on counts.
REQ-022 Only addresses 0..35 SHALL be accessed; bytes 0..32 SHALL never be written.
REQ-023 When idle, dm_addr=0, dm_wr_en=0 and dm_wr_data=0.

Reset
REQ-024 reset=1 at an edge -> IDLE; done=0, busy=0, dm_wr_en=0; counters, index and pat cleared.
REQ-025 reset overrides start at the same edge.
REQ-026 reset mid-job SHALL abort with no further writes; memory already written stays as written.

Verification
REQ-027 mem[0..31]=0x00, mem[32]=0x15 (10101), pulse start -> done at E36; mem[33..35]=0,0,0.
REQ-028 mem[0..31]=0x55, mem[32]=0x15 -> mem[33]=64, mem[34]=32, mem[35]=126.
REQ-029 mem[0..31]=0xFF, mem[32]=0xFF (pattern 11111, upper bits ignored) -> mem[33]=128, mem[34]=32, mem[35]=252.
REQ-030 Byte-crossing only: mem[5]=0x07, mem[6]=0xC0, all other bytes 0x00, mem[32]=0x1F -> mem[33]=0, mem[34]=0, mem[35]=1.
REQ-031 Preload mem[33..35]=0xAA, start, then reset at E10 -> done stays 0, busy drops after that edge, mem[33..35] remain 0xAA; a new start then gives correct results at E36.
REQ-032 start pulsed again at E5 (busy) -> ignored; timing unchanged. start while in DONE -> done drops at that edge and the job reruns with identical results.
